// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier: DAZ/FTZ, five rounding modes, overflow/underflow flags.
// Define FP_MUL_NAN_EN to decode NaNs, return a canonical qNaN and drive the nv flag.
module fp_mul_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRC_W  = 23,
    parameter int unsigned STAGES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf,
    output logic                   nv
);
    localparam int unsigned W  = 1 + EXP_W + FRC_W;
    localparam int unsigned PW = 2 * FRC_W + 2;
    localparam int unsigned EW = EXP_W + 2;

    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [EW-1:0]        BIAS    = {3'b000, {(EXP_W-1){1'b1}}};
    localparam logic signed [EW-1:0] EXP_MAX = {2'b00, {EXP_W{1'b1}}};
    localparam logic signed [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [W-2:0] INF_MAG = {{EXP_W{1'b1}}, {FRC_W{1'b0}}};
    localparam logic [W-2:0] MAX_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {FRC_W{1'b1}}};
    localparam logic [W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};

    typedef struct packed {
        logic          valid;
        logic          sign;
        logic [2:0]    rm;
        logic          is_nan;
        logic          is_inf;
        logic          is_zero;
        logic          nv;
        logic [EW-1:0] exp;
    } meta_t;

    typedef struct packed { meta_t m; logic [PW-1:0] prod; } prd_t;
    typedef struct packed { meta_t m; logic [FRC_W-1:0] frac; logic g; logic s; } nrm_t;
    typedef struct packed { meta_t m; logic [FRC_W-1:0] frac; } rnd_t;

    prd_t prd_d, prd;
    nrm_t nrm_d, nrm;
    rnd_t rnd_d, rnd;

    logic             advance;
    logic [EXP_W-1:0] ex, ey;
    logic [FRC_W-1:0] fx, fy;
    logic             zx, zy, ix, iy;
    logic             inc;
    logic [FRC_W:0]   rsum;
    logic             ovf, udf;
    logic [W-1:0]     res_z;
    logic             res_o, res_u;

    logic             out_valid_d, out_valid_q;
    logic [W-1:0]     fp_z_d, fp_z_q;
    logic             ovrf_d, ovrf_q, udrf_d, udrf_q, nv_d, nv_q;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign fp_Z      = fp_z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;
    assign nv        = nv_q;

    // Decode operands and form the full significand product.
    always_comb begin
        ex = fp_X[W-2 -: EXP_W];
        ey = fp_Y[W-2 -: EXP_W];
        fx = fp_X[FRC_W-1:0];
        fy = fp_Y[FRC_W-1:0];
        zx = (ex == '0);
        zy = (ey == '0);
        ix = (ex == '1);
        iy = (ey == '1);
        prd_d           = '0;
        prd_d.m.valid   = in_valid;
        prd_d.m.sign    = fp_X[W-1] ^ fp_Y[W-1];
        prd_d.m.rm      = r_mode;
        prd_d.m.is_zero = (zx || zy) && !(ix || iy);
`ifdef FP_MUL_NAN_EN
        prd_d.m.is_nan  = (ix && (fx != '0)) || (iy && (fy != '0)) || (ix && zy) || (iy && zx);
        prd_d.m.nv      = (ix && (fx != '0) && !fx[FRC_W-1]) || (iy && (fy != '0) && !fy[FRC_W-1])
                          || (ix && zy) || (iy && zx);
        prd_d.m.is_inf  = (ix || iy) && !prd_d.m.is_nan;
`else
        prd_d.m.is_nan  = 1'b0;
        prd_d.m.nv      = 1'b0;
        prd_d.m.is_inf  = ix || iy;
`endif
        prd_d.m.exp     = {2'b00, ex} + {2'b00, ey} - BIAS;
        prd_d.prod      = {{(FRC_W+1){1'b0}}, 1'b1, fx} * {{(FRC_W+1){1'b0}}, 1'b1, fy};
    end

    // Normalise: the leading one sits at bit PW-1 or PW-2.
    always_comb begin
        nrm_d   = '0;
        nrm_d.m = prd.m;
        if (prd.prod[PW-1]) begin
            nrm_d.frac  = prd.prod[PW-2 -: FRC_W];
            nrm_d.g     = prd.prod[FRC_W];
            nrm_d.s     = |prd.prod[FRC_W-1:0];
            nrm_d.m.exp = prd.m.exp + {{(EW-1){1'b0}}, 1'b1};
        end else begin
            nrm_d.frac  = prd.prod[PW-3 -: FRC_W];
            nrm_d.g     = prd.prod[FRC_W-1];
            nrm_d.s     = |prd.prod[FRC_W-2:0];
        end
    end

    always_comb begin
        case (nrm.m.rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = nrm.m.sign && (nrm.g || nrm.s);
            RM_RUP:  inc = !nrm.m.sign && (nrm.g || nrm.s);
            RM_RMM:  inc = nrm.g;
            default: inc = nrm.g && (nrm.s || nrm.frac[0]);
        endcase
        rsum        = {1'b0, nrm.frac} + {{FRC_W{1'b0}}, inc};
        // A carry out leaves the fraction all-zero, so only the exponent needs bumping.
        rnd_d.m     = nrm.m;
        rnd_d.frac  = rsum[FRC_W-1:0];
        rnd_d.m.exp = nrm.m.exp + {{(EW-1){1'b0}}, rsum[FRC_W]};
    end

    always_comb begin
        ovf   = $signed(rnd.m.exp) >= EXP_MAX;
        udf   = $signed(rnd.m.exp) < EXP_ONE;
        res_z = {rnd.m.sign, rnd.m.exp[EXP_W-1:0], rnd.frac};
        res_o = 1'b0;
        res_u = 1'b0;
        if (rnd.m.is_nan) begin
            res_z = QNAN;
        end else if (rnd.m.is_inf) begin
            res_z = {rnd.m.sign, INF_MAG};
        end else if (rnd.m.is_zero) begin
            res_z = {rnd.m.sign, {(W-1){1'b0}}};
        end else if (ovf) begin
            res_o = 1'b1;
            case (rnd.m.rm)
                RM_RTZ:  res_z = {rnd.m.sign, MAX_MAG};
                RM_RDN:  res_z = {rnd.m.sign, rnd.m.sign ? INF_MAG : MAX_MAG};
                RM_RUP:  res_z = {rnd.m.sign, rnd.m.sign ? MAX_MAG : INF_MAG};
                default: res_z = {rnd.m.sign, INF_MAG};
            endcase
        end else if (udf) begin
            res_u = 1'b1;
            res_z = {rnd.m.sign, {(W-1){1'b0}}};
        end
        out_valid_d = advance ? rnd.m.valid : out_valid_q;
        fp_z_d      = fp_z_q;
        ovrf_d      = ovrf_q;
        udrf_d      = udrf_q;
        nv_d        = nv_q;
        if (advance && rnd.m.valid) begin
            fp_z_d = res_z;
            ovrf_d = res_o;
            udrf_d = res_u;
            nv_d   = rnd.m.nv;
        end
    end

    if (STAGES >= 2) begin : g_prd_reg
        prd_t prd_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       prd_q <= '0;
            else if (advance) prd_q <= prd_d;
        end
        assign prd = prd_q;
    end else begin : g_prd_comb
        assign prd = prd_d;
    end

    if (STAGES >= 3) begin : g_nrm_reg
        nrm_t nrm_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       nrm_q <= '0;
            else if (advance) nrm_q <= nrm_d;
        end
        assign nrm = nrm_q;
    end else begin : g_nrm_comb
        assign nrm = nrm_d;
    end

    if (STAGES >= 4) begin : g_rnd_reg
        rnd_t rnd_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       rnd_q <= '0;
            else if (advance) rnd_q <= rnd_d;
        end
        assign rnd = rnd_q;
    end else begin : g_rnd_comb
        assign rnd = rnd_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            fp_z_q      <= '0;
            ovrf_q      <= 1'b0;
            udrf_q      <= 1'b0;
            nv_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            fp_z_q      <= fp_z_d;
            ovrf_q      <= ovrf_d;
            udrf_q      <= udrf_d;
            nv_q        <= nv_d;
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe in FP32 with three stages; honours FP_MUL_NAN_EN.
// Expected results are queued on acceptance and compared in order on each output transfer.
module tb_fp_mul_pipe;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRC_W  = 23;
    localparam int unsigned STAGES = 3;
    localparam int unsigned W      = 32;

    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready, ovrf, udrf, nv;
    logic [W-1:0] fp_X, fp_Y, fp_Z;
    logic [2:0]   r_mode;

    int           n_total = 0;
    int           n_pass  = 0;
    int           n_out   = 0;
    logic [W+2:0] exp_cur;
    logic [W+2:0] sb_q[$];

    fp_mul_pipe #(
        .EXP_W (EXP_W),
        .FRC_W (FRC_W),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .fp_X     (fp_X),
        .fp_Y     (fp_Y),
        .r_mode   (r_mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .fp_Z     (fp_Z),
        .ovrf     (ovrf),
        .udrf     (udrf),
        .nv       (nv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_total++;
        assert (obs === req) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    endtask

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb_q.push_back(exp_cur);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
                else check($sformatf("result%0d", n_out), 64'({fp_Z, ovrf, udrf, nv}),
                           64'(sb_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] rm,
                         input logic [W+2:0] e);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        fp_X = x; fp_Y = y; r_mode = rm; exp_cur = e; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("issue_timeout", 64'(acc), 64'(1));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        int lat;
        int n0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fp_X = '0; fp_Y = '0; r_mode = RNE; exp_cur = '0;
        @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_outputs", 64'({fp_Z, ovrf, udrf, nv}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        #5 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic product and latency
        issue(32'h3FC00000, 32'h40000000, RNE, {32'h40400000, 3'b000});
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(STAGES));
        drain("drain_basic");

        // Zero, subnormal, infinity, overflow, underflow and rounding, back-to-back
        issue(32'h00000001, 32'h3F800000, RNE, {32'h00000000, 3'b000});
        issue(32'h80000000, 32'h40000000, RNE, {32'h80000000, 3'b000});
        issue(32'h7F7FFFFF, 32'h40000000, RNE, {32'h7F800000, 3'b100});
        issue(32'h7F7FFFFF, 32'h40000000, RTZ, {32'h7F7FFFFF, 3'b100});
        issue(32'hFF7FFFFF, 32'h40000000, RDN, {32'hFF800000, 3'b100});
        issue(32'h7F7FFFFF, 32'h40000000, RDN, {32'h7F7FFFFF, 3'b100});
        issue(32'h7F7FFFFF, 32'h40000000, RUP, {32'h7F800000, 3'b100});
        issue(32'hFF7FFFFF, 32'h40000000, RUP, {32'hFF7FFFFF, 3'b100});
        issue(32'h7F7FFFFF, 32'h40000000, RMM, {32'h7F800000, 3'b100});
        issue(32'h7F7FFFFF, 32'h40000000, 3'd5, {32'h7F800000, 3'b100});
        issue(32'h00800000, 32'h3F000000, RNE, {32'h00000000, 3'b010});
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        issue(32'h3F800001, 32'h3F800001, RNE, {32'h3F800002, 3'b000});
        issue(32'h3F800001, 32'h3F800001, RUP, {32'h3F800003, 3'b000});
        issue(32'hBF800001, 32'h3F800001, RDN, {32'hBF800003, 3'b000});
        issue(32'hBF800001, 32'h3F800001, RUP, {32'hBF800002, 3'b000});
        issue(32'h3FC00000, 32'h3F800003, RNE, {32'h3FC00004, 3'b000});
        issue(32'h3FC00000, 32'h3F800003, RMM, {32'h3FC00005, 3'b000});
        issue(32'h3FC00000, 32'h3F800003, 3'd7, {32'h3FC00004, 3'b000});
        issue(32'h3F800001, 32'h3FFFFFFE, RNE, {32'h40000000, 3'b000});
        issue(32'h3F800001, 32'h3FFFFFFE, RTZ, {32'h3FFFFFFF, 3'b000});
        issue(32'h7F800000, 32'hC0000000, RNE, {32'hFF800000, 3'b000});
        issue(32'hC0000000, 32'h40400000, RNE, {32'hC0C00000, 3'b000});
`ifdef FP_MUL_NAN_EN
        issue(32'h7F800000, 32'h00000000, RNE, {32'h7FC00000, 3'b001});
        issue(32'h7F800001, 32'h3F800000, RNE, {32'h7FC00000, 3'b001});
        issue(32'h7FC00000, 32'h3F800000, RNE, {32'h7FC00000, 3'b000});
`else
        issue(32'h7F800000, 32'h00000000, RNE, {32'h7F800000, 3'b000});
        issue(32'h7F800001, 32'h3F800000, RNE, {32'h7F800000, 3'b000});
`endif
        in_valid = 1'b0;
        drain("drain_vectors");

        // Backpressure: three in flight, stall five cycles with a pending request
        n0 = n_out;
        issue(32'h3F800000, 32'h3F800000, RNE, {32'h3F800000, 3'b000});
        issue(32'hC0000000, 32'h40400000, RNE, {32'hC0C00000, 3'b000});
        issue(32'h3F800001, 32'h3FFFFFFE, RNE, {32'h40000000, 3'b000});
        out_ready = 1'b0;
        fp_X = 32'h3FC00000; fp_Y = 32'h40000000; r_mode = RNE;
        exp_cur = {32'h40400000, 3'b000};
        check("bp_valid", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'(0));
            check($sformatf("bp_hold%0d", i), 64'({fp_Z, ovrf, udrf, nv}),
                  64'({32'h3F800000, 3'b000}));
        end
        check("bp_none_accepted", 64'(sb_q.size()), 64'(3));
        out_ready = 1'b1;
        issue(32'h3FC00000, 32'h40000000, RNE, {32'h40400000, 3'b000});
        in_valid = 1'b0;
        drain("drain_bp");
        check("bp_count", 64'(n_out - n0), 64'(4));

        // Reset in the middle of a stream
        issue(32'h3F800000, 32'h40000000, RNE, {32'h40000000, 3'b000});
        issue(32'h40000000, 32'h40000000, RNE, {32'h40800000, 3'b000});
        issue(32'h40400000, 32'h40000000, RNE, {32'h40C00000, 3'b000});
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_outputs", 64'({fp_Z, ovrf, udrf, nv}), 64'(0));
        sb_q.delete();
        n0 = n_out;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(n_out - n0), 64'(0));
        check("rst_idle_valid", 64'(out_valid), 64'(0));

        issue(32'h3FC00000, 32'h40000000, RNE, {32'h40400000, 3'b000});
        in_valid = 1'b0;
        drain("drain_after_rst");
        check("after_rst_count", 64'(n_out - n0), 64'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
